dma_line_status: RTL and testbench



---
 rtl/dma_status_pkg.sv | 23 ++
 rtl/dma_timeout_cnt.sv | 35 +++
 rtl/dma_line_status.sv | 175 +++++++++++++++++
 tb/tb_dma_line_status.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_status_pkg.sv
// Shared types and status-word layout for the scanner line-buffer DMA tracker.
package dma_status_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    // Bit positions inside the 32-bit status word read by the HPS
    localparam int LINE_CNT_LSB = 0;
    localparam int FILL_LSB     = 16;
    localparam int WIDX_LSB     = 20;
    localparam int OVF_BIT      = 23;
    localparam int DROP_LSB     = 24;
    localparam int TMO_BIT      = 28;
    localparam int ERR_BIT      = 29;
    localparam int STATE_LSB    = 30;

    localparam logic [3:0] DROP_MAX = 4'd15;

endpackage

// File: rtl/dma_timeout_cnt.sv
// Grant-to-done watchdog: reloads on clear_i, counts down while en_i, flags expiry at zero.
module dma_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/dma_line_status.sv
// Line-buffer ring tracker for the scanner DMA path, packed into a 32-bit status word.
// Optional level interrupt output enabled by defining DMA_STATUS_IRQ_EN.
module dma_line_status
    import dma_status_pkg::*;
#(
    parameter int NUM_BUFS       = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int LINE_CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        line_start,
    input  logic        line_done,
    input  logic        dma_error,
    input  logic        buf_release,
    output logic        dma_go,
    output logic [2:0]  buf_wr_idx,
    output logic [31:0] status_o
`ifdef DMA_STATUS_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int IDX_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam logic [3:0] FILL_FULL = 4'(NUM_BUFS);

    state_e                state_q, state_d;
    logic                  en_q;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [3:0]            fill_q, fill_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic [3:0]            drop_q, drop_d;
    logic                  ovf_q, ovf_d, tmo_q, tmo_d, err_q, err_d;
    logic                  go_q, go_d;
    logic [31:0]           status_q, status_d;
    logic                  en_rise, done_ok, rel_ok, tmo_expire;

    dma_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (go_d),
        .en_i     (state_q == ST_XFER),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d    = state_q;
        line_cnt_d = line_cnt_q;
        fill_d     = fill_q;
        widx_d     = widx_q;
        drop_d     = drop_q;
        ovf_d      = ovf_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        go_d       = 1'b0;
        done_ok    = 1'b0;
        en_rise    = enable && !en_q;
        rel_ok     = buf_release && (fill_q != 4'd0);

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (line_start) begin
                        if (fill_q < FILL_FULL) begin
                            go_d    = 1'b1;
                            state_d = ST_XFER;
                        end else begin
                            ovf_d = 1'b1;
                            if (drop_q != DROP_MAX) drop_d = drop_q + 4'd1;
                        end
                    end
                end
                ST_XFER: begin
                    // An error in the same cycle as line_done discards the line
                    if (dma_error) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else if (line_done) begin
                        done_ok = 1'b1;
                        state_d = ST_ARMED;
                    end else if (tmo_expire) begin
                        tmo_d   = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        if (done_ok) begin
            line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
            widx_d     = widx_q + IDX_W'(1);
        end

        case ({done_ok, rel_ok})
            2'b10:   fill_d = fill_q + 4'd1;
            2'b01:   fill_d = fill_q - 4'd1;
            default: fill_d = fill_q;
        endcase

        // A fresh capture session starts from a clean slate
        if (en_rise) begin
            line_cnt_d = '0;
            fill_d     = '0;
            widx_d     = '0;
            drop_d     = '0;
            ovf_d      = 1'b0;
            tmo_d      = 1'b0;
            err_d      = 1'b0;
        end

        status_d                             = '0;
        status_d[LINE_CNT_LSB +: LINE_CNT_W] = line_cnt_d;
        status_d[FILL_LSB +: 4]              = fill_d;
        status_d[WIDX_LSB +: 3]              = 3'(widx_d);
        status_d[OVF_BIT]                    = ovf_d;
        status_d[DROP_LSB +: 4]              = drop_d;
        status_d[TMO_BIT]                    = tmo_d;
        status_d[ERR_BIT]                    = err_d;
        status_d[STATE_LSB +: 2]             = state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            line_cnt_q <= '0;
            fill_q     <= '0;
            widx_q     <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            err_q      <= 1'b0;
            go_q       <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= enable;
            line_cnt_q <= line_cnt_d;
            fill_q     <= fill_d;
            widx_q     <= widx_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            go_q       <= go_d;
            status_q   <= status_d;
        end
    end

    assign dma_go     = go_q;
    assign buf_wr_idx = 3'(widx_q);
    assign status_o   = status_q;

`ifdef DMA_STATUS_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (fill_d != 4'd0) || (state_d == ST_ERROR);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_dma_line_status.sv
// Directed and randomized bench for dma_line_status against a behavioural ring model.
module tb_dma_line_status;

    localparam int NB = 4;
    localparam int T  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        line_start = 1'b0;
    logic        line_done = 1'b0;
    logic        dma_error = 1'b0;
    logic        buf_release = 1'b0;
    logic        dma_go;
    logic [2:0]  buf_wr_idx;
    logic [31:0] status_o;
`ifdef DMA_STATUS_IRQ_EN
    logic        irq;
`endif

    dma_line_status #(
        .NUM_BUFS       (NB),
        .TIMEOUT_CYCLES (T),
        .LINE_CNT_W     (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .line_start  (line_start),
        .line_done   (line_done),
        .dma_error   (dma_error),
        .buf_release (buf_release),
        .dma_go      (dma_go),
        .buf_wr_idx  (buf_wr_idx),
        .status_o    (status_o)
`ifdef DMA_STATUS_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: state 0 idle, 1 armed, 2 transferring, 3 error
    int m_state, m_lines, m_fill, m_widx, m_drop, m_ovf, m_tmo, m_err, m_go;
    int m_en_prev, m_grant_cyc, cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lines = 0; m_fill = 0; m_widx = 0; m_drop = 0;
        m_ovf = 0; m_tmo = 0; m_err = 0; m_go = 0; m_en_prev = 0; m_grant_cyc = 0;
    endtask

    task automatic model_edge(input bit en, input bit ls, input bit ld, input bit de, input bit br);
        int nxt;
        bit done, rise, rel;
        cyc++;
        m_go = 0;
        done = 0;
        nxt  = m_state;
        rise = en && (m_en_prev == 0);
        m_en_prev = en ? 1 : 0;
        rel  = br && (m_fill > 0);
        if (!en) nxt = 0;
        else if (m_state == 0) nxt = 1;
        else if (m_state == 1 && ls) begin
            if (m_fill < NB) begin
                m_go = 1; nxt = 2; m_grant_cyc = cyc;
            end else begin
                m_ovf = 1;
                m_drop = (m_drop >= 15) ? 15 : m_drop + 1;
            end
        end else if (m_state == 2) begin
            if (de) begin m_err = 1; nxt = 3; end
            else if (ld) begin done = 1; nxt = 1; end
            else if (cyc - m_grant_cyc >= T) begin m_tmo = 1; nxt = 3; end
        end
        if (done) begin
            m_lines = (m_lines + 1) % 65536;
            m_widx  = (m_widx + 1) % NB;
        end
        m_fill = m_fill + (done ? 1 : 0) - (rel ? 1 : 0);
        if (rise) begin
            m_lines = 0; m_fill = 0; m_widx = 0; m_drop = 0;
            m_ovf = 0; m_tmo = 0; m_err = 0;
        end
        m_state = nxt;
    endtask

    task automatic check_all();
        logic [31:0] exp;
        exp = 32'(m_lines) + 32'(m_fill * 65536) + 32'(m_widx * (1 << 20)) + 32'(m_ovf * (1 << 23))
            + 32'(m_drop * (1 << 24)) + 32'(m_tmo * (1 << 28)) + 32'(m_err * (1 << 29));
        exp = exp + (32'(m_state) << 30);
        chk("status", status_o, exp);
        chk("dma_go", 32'(dma_go), 32'(m_go));
        chk("buf_wr_idx", 32'(buf_wr_idx), 32'(m_widx));
`ifdef DMA_STATUS_IRQ_EN
        chk("irq", 32'(irq), 32'((m_fill > 0 || m_state == 3) ? 1 : 0));
`endif
    endtask

    task automatic step(input bit en, input bit ls, input bit ld, input bit de, input bit br);
        @(negedge clk);
        enable = en; line_start = ls; line_done = ld; dma_error = de; buf_release = br;
        @(posedge clk);
        model_edge(en, ls, ld, de, br);
        #1;
        check_all();
    endtask

    initial begin
        cyc = 0;
        model_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_status", status_o, 32'h0);
        chk("reset_go", 32'(dma_go), 32'h0);
        chk("reset_widx", 32'(buf_wr_idx), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // First grant and completion
        step(1, 0, 0, 0, 0);
        chk("armed_state", 32'(status_o[31:30]), 32'd1);
        step(1, 1, 0, 0, 0);
        chk("go_pulse", 32'(dma_go), 32'd1);
        chk("go_widx", 32'(buf_wr_idx), 32'd0);
        step(1, 0, 0, 0, 0);
        chk("go_one_cycle", 32'(dma_go), 32'd0);
        step(1, 0, 1, 0, 0);
        chk("first_line_cnt", 32'(status_o[15:0]), 32'd1);
        chk("first_fill", 32'(status_o[19:16]), 32'd1);
        chk("first_widx", 32'(status_o[22:20]), 32'd1);
        chk("first_state", 32'(status_o[31:30]), 32'd1);

        // Fill the ring, then overflow and saturate drops
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0);
            step(1, 0, 1, 0, 0);
        end
        chk("full_fill", 32'(status_o[19:16]), 32'd4);
        step(1, 1, 0, 0, 0);
        chk("drop_no_go", 32'(dma_go), 32'd0);
        chk("drop_ovf", 32'(status_o[23]), 32'd1);
        chk("drop_cnt1", 32'(status_o[27:24]), 32'd1);
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
        chk("drop_sat", 32'(status_o[27:24]), 32'd15);

        // Simultaneous done and release, then release while empty
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1);
        chk("done_rel_fill", 32'(status_o[19:16]), 32'd2);
        chk("done_rel_lines", 32'(status_o[15:0]), 32'd5);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("rel_empty", 32'(status_o[19:16]), 32'd0);

        // Watchdog expiry exactly T cycles after the grant
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < T - 1; i++) step(1, 0, 0, 0, 0);
        chk("tmo_not_early", 32'(status_o[31:28]), 32'b1000);
        step(1, 0, 0, 0, 0);
        chk("tmo_state", 32'(status_o[31:30]), 32'd3);
        chk("tmo_bit", 32'(status_o[28]), 32'd1);
        step(0, 0, 0, 0, 0);
        chk("disable_holds", 32'(status_o[28]), 32'd1);
        step(1, 0, 0, 0, 0);
        chk("rise_clears", status_o, 32'h4000_0000);

        // Error wins over a coincident line_done
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        chk("err_bit", 32'(status_o[29]), 32'd1);
        chk("err_state", 32'(status_o[31:30]), 32'd3);
        chk("err_lines", 32'(status_o[15:0]), 32'd0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

`ifdef DMA_STATUS_IRQ_EN
        chk("irq_idle", 32'(irq), 32'd0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("irq_rise", 32'(irq), 32'd1);
        step(1, 0, 0, 0, 1);
        chk("irq_fall", 32'(irq), 32'd0);
`else
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
`endif

        // Asynchronous reset in the middle of a transfer
        step(1, 1, 0, 0, 0);
        @(negedge clk);
        enable = 1'b0; line_start = 1'b0; line_done = 1'b0; dma_error = 1'b0; buf_release = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_status", status_o, 32'h0);
        chk("async_go", 32'(dma_go), 32'h0);
        chk("async_widx", 32'(buf_wr_idx), 32'h0);
`ifdef DMA_STATUS_IRQ_EN
        chk("async_irq", 32'(irq), 32'h0);
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit en, ls, ld, de, br;
            en = ($urandom_range(0, 99) >= 3);
            ls = ($urandom_range(0, 99) < 25);
            ld = ($urandom_range(0, 99) < 15);
            de = ($urandom_range(0, 99) < 2);
            br = ($urandom_range(0, 99) < 20);
            step(en, ls, ld, de, br);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
